// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed 7-segment display driver. Hex nibbles, decimal-point
//   requests and blank requests are captured into shadow registers on `load`.
//   A prescaler steps a digit index once every SCAN_DIV cycles. Every cycle the
//   registered outputs show the decoded shadow digit selected by the index.
//
// Parameters
//   NDIG     number of multiplexed digits (1..8)
//   SCAN_DIV clock cycles per digit slot (>=1)
//   CA       1 = common-anode (all outputs active-low), 0 = common-cathode
//   LZS      1 = leading-zero suppression
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   load    in   capture strobe for bin/dp/blank
//   bin     in   4*NDIG hex nibbles, digit k at bin[4k+3:4k], digit 0 rightmost
//   dp      in   NDIG decimal-point requests, 1 = lit
//   blank   in   NDIG blank requests, 1 = dark
//   seg     out  segments a..g, seg[1] = a, registered
//   dp_out  out  decimal-point segment, registered
//   an      out  NDIG digit enables, at most one active, registered
module seg_scan_driver #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 100000,
    parameter int CA       = 1,
    parameter int LZS      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4*NDIG-1:0] bin,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   blank,
    output logic [1:7]        seg,
    output logic              dp_out,
    output logic [NDIG-1:0]   an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(NDIG - 1);
    localparam logic          INV  = (CA != 0);

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] bin_q;
    logic [NDIG-1:0]   dp_q, blank_q;
    logic [1:7]        seg_q, seg_d;
    logic              dpo_q, dpo_d;
    logic [NDIG-1:0]   an_q, an_d;

    logic              tick;
    logic [3:0]        nib;
    logic              nib_dp, nib_blank, zero_above, dark;
    logic [1:7]        dec;
    logic [NDIG-1:0]   an_hi;

    assign tick = (presc_q == PMAX);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IMAX) ? '0 : idx_q + 1'b1;
        end
    end

    // Select the indexed digit's shadow fields and check whether this digit
    // and every more significant digit are zero (for leading-zero suppression).
    always_comb begin
        nib        = '0;
        nib_dp     = 1'b0;
        nib_blank  = 1'b0;
        zero_above = 1'b1;
        an_hi      = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (k == 32'(idx_q)) begin
                nib       = bin_q[4*k +: 4];
                nib_dp    = dp_q[k];
                nib_blank = blank_q[k];
                an_hi[k]  = 1'b1;
            end
            if (k >= 32'(idx_q) && bin_q[4*k +: 4] != 4'h0) begin
                zero_above = 1'b0;
            end
        end
        dark = nib_blank || ((LZS != 0) && zero_above && (idx_q != '0));
    end

    always_comb begin
        dec = 7'b0000000;
        case (nib)
            4'h0: dec = 7'b1111110;
            4'h1: dec = 7'b0110000;
            4'h2: dec = 7'b1101101;
            4'h3: dec = 7'b1111001;
            4'h4: dec = 7'b0110011;
            4'h5: dec = 7'b1011011;
            4'h6: dec = 7'b1011111;
            4'h7: dec = 7'b1110010;
            4'h8: dec = 7'b1111111;
            4'h9: dec = 7'b1110011;
            4'hA: dec = 7'b1110111;
            4'hB: dec = 7'b0011111;
            4'hC: dec = 7'b1001110;
            4'hD: dec = 7'b0111101;
            4'hE: dec = 7'b1001111;
            4'hF: dec = 7'b1000111;
            default: dec = 7'b0000000;
        endcase
    end

    // Build active-high values, then flip polarity for common-anode parts.
    always_comb begin
        seg_d = (dark ? 7'b0000000 : dec) ^ {7{INV}};
        dpo_d = (!dark && nib_dp) ^ INV;
        an_d  = (dark ? '0 : an_hi) ^ {NDIG{INV}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            bin_q   <= '0;
            dp_q    <= '0;
            blank_q <= '1;
            seg_q   <= {7{INV}};
            dpo_q   <= INV;
            an_q    <= {NDIG{INV}};
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (load) begin
                bin_q   <= bin;
                dp_q    <= dp;
                blank_q <= blank;
            end
            seg_q <= seg_d;
            dpo_q <= dpo_d;
            an_q  <= an_d;
        end
    end

    assign seg    = seg_q;
    assign dp_out = dpo_q;
    assign an     = an_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of multiplexed digits, 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 100000: clock cycles per digit slot, >=1.
REQ-003 SHALL have parameter CA, default 1: 1 = common-anode (segments and anodes active-low), 0 = common-cathode (active-high).
REQ-004 SHALL have parameter LZS, default 0: 1 = leading-zero suppression enabled.
REQ-005 SHALL have port clk  input  1: the single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-007 SHALL have port load  input  1: capture strobe for bin, dp, blank.
REQ-008 SHALL have port bin  input  4*NDIG: hex nibbles, digit k at bin[4k+3:4k], digit 0 rightmost.
REQ-009 SHALL have port dp  input  NDIG: decimal-point request per digit, 1 = lit.
REQ-010 SHALL have port blank  input  NDIG: per-digit blank request, 1 = dark.
REQ-011 SHALL have port seg  output  7 [1:7]: segments a..g, seg[1]=a, registered.
REQ-012 SHALL have port dp_out  output  1: decimal-point segment, registered.
REQ-013 SHALL have port an  output  NDIG: digit enables, one active at most, registered.

Function
REQ-014 SHALL, on rising clk with load=1, copy bin, dp, blank into shadow registers; shadow otherwise holds.
REQ-015 SHALL run prescaler 0..SCAN_DIV-1, wrapping to 0; tick = prescaler at SCAN_DIV-1 (SCAN_DIV=1: tick every cycle).
REQ-016 SHALL advance digit index on tick, NDIG-1 wraps to 0; NDIG=1 keeps index 0.
REQ-017 SHALL register seg/dp_out/an every cycle from current index and shadow; outputs lag index change by 1 cycle; load-to-visible latency 2 cycles.
REQ-018 SHALL decode nibble (abcdefg, active-high form) 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110010 8=1111111 9=1110011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111.
REQ-019 SHALL invert seg, dp_out and an when CA=1.
REQ-020 SHALL treat digit as dark when shadow blank bit set, or LZS=1 and it and all higher digits are 0 and index != 0.
REQ-021 SHALL, for a dark digit, drive all segments, dp_out and all an inactive for the whole slot.
REQ-022 SHALL, for a lit digit, drive exactly the indexed an bit active.
REQ-023 SHALL, on load coinciding with tick, use the new shadow from the following cycle's output computation (no special case).
REQ-024 SHALL make dp lit on a non-blank-requested digit even if LZS-suppressed? No: LZS-dark digits SHALL show no dp.

Reset
REQ-025 SHALL, on reset assertion, immediately (asynchronously) set prescaler=0, index=0, shadow bin=0, shadow dp=0, shadow blank=all 1.
REQ-026 SHALL, during reset, hold seg and dp_out inactive (CA=1: 7'b1111111, 1) and an all inactive.
REQ-027 SHALL ignore load while reset is high; first scan slot after release is digit 0, full SCAN_DIV cycles.

Verification (NDIG=4, SCAN_DIV=4, CA=1, LZS=0 unless noted)
REQ-028 Reset pulse mid-scan -> seg=1111111, dp_out=1, an=1111 immediately; after release, digit 0 slot first; display dark until load.
REQ-029 load bin=16'h1234, dp=0, blank=0 at index 0 -> 2 cycles later seg=1001100, an=1110, dp_out=1.
REQ-030 Free-run after REQ-029 -> an sequence 1110,1101,1011,0111,1110, each held 4 cycles; seg 1001100,0000110,0010010,1001111.
REQ-031 LZS=1, load bin=16'h0005 -> digits 3..1 slots an=1111, seg=1111111; digit 0 slot seg=0100100, an=1110; bin=16'h0000 -> digit 0 shows 0 (0000001).
REQ-032 load blank=4'b0010, dp=4'b0010, bin=16'hFFFF -> digit 1 slot fully dark incl. dp_out=1; others seg=0111000.
REQ-033 CA=0, SCAN_DIV=1, load bin=16'h000F -> digit 0 cycle seg=1000111, an=0001; index advances every cycle.
